// File: rtl/alu_accumulator.sv
// Accumulator front-end for an external combinational ALU: accepts one command,
// drives the ALU for one EXEC cycle, then writes the result back into the accumulator.
module alu_accumulator #(
  parameter int data_width = 16
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  clear,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic                  in_load,
  input  logic [3:0]            in_func,
  input  logic [data_width-1:0] in_operand,
  output logic [data_width-1:0] alu_a,
  output logic [data_width-1:0] alu_b,
  output logic [3:0]            alu_func,
  input  logic [data_width-1:0] alu_c,
  input  logic                  alu_overflow,
  output logic [data_width-1:0] acc_out,
  output logic                  out_valid,
  output logic                  ovf_sticky,
  output logic [7:0]            op_count
);

  typedef enum logic {IDLE, EXEC} state_t;

  state_t                state, stateNext;
  logic                  accept;
  logic                  vld_p0;
  logic                  cmdLoad_p0;
  logic [3:0]            cmdFunc_p0;
  logic [data_width-1:0] cmdOperand_p0;
  logic [data_width-1:0] cmdAcc_p0;
  logic [data_width-1:0] acc_p1;
  logic                  vld_p1;
  logic                  ovf_p1;
  logic [7:0]            count_p1;

  function automatic logic [7:0] satInc(input logic [7:0] c);
    return (c == 8'hFF) ? c : c + 8'd1;
  endfunction

  assign in_ready = (state == IDLE) && !clear;
  assign accept   = in_valid && in_ready;
  assign vld_p0   = (state == EXEC) && !clear;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= stateNext;
  end

  always_comb begin
    stateNext = state;
    if (clear) begin
      stateNext = IDLE;
    end else begin
      case (state)
        IDLE:    if (accept) stateNext = EXEC;
        EXEC:    stateNext = IDLE;
        default: stateNext = IDLE;
      endcase
    end
  end

  // Stage p0: command capture; these registers also drive the ALU ports and
  // simply hold between commands so the ALU inputs never toggle outside EXEC.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cmdLoad_p0    <= 1'b0;
      cmdFunc_p0    <= '0;
      cmdOperand_p0 <= '0;
      cmdAcc_p0     <= '0;
    end else if (accept) begin
      cmdLoad_p0    <= in_load;
      cmdFunc_p0    <= in_func;
      cmdOperand_p0 <= in_operand;
      cmdAcc_p0     <= acc_p1;
    end
  end

  assign alu_a    = cmdAcc_p0;
  assign alu_b    = cmdOperand_p0;
  assign alu_func = cmdFunc_p0;

  // Stage p1: writeback at the end of EXEC; clear discards the in-flight command.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      acc_p1   <= '0;
      vld_p1   <= 1'b0;
      ovf_p1   <= 1'b0;
      count_p1 <= '0;
    end else if (clear) begin
      acc_p1   <= '0;
      vld_p1   <= 1'b0;
      ovf_p1   <= 1'b0;
      count_p1 <= '0;
    end else begin
      vld_p1 <= vld_p0;
      if (vld_p0) begin
        acc_p1   <= cmdLoad_p0 ? cmdOperand_p0 : alu_c;
        count_p1 <= satInc(count_p1);
        if (!cmdLoad_p0 && alu_overflow) ovf_p1 <= 1'b1;
      end
    end
  end

  assign acc_out    = acc_p1;
  assign out_valid  = vld_p1;
  assign ovf_sticky = ovf_p1;
  assign op_count   = count_p1;

endmodule

// File: tb/tb_alu_accumulator.sv
// Directed bench for alu_accumulator with a small behavioural 16-bit ALU attached.
module tb_alu_accumulator;

  localparam int DW = 16;
  localparam logic [3:0] FN_ID  = 4'h0;
  localparam logic [3:0] FN_ADD = 4'h2;
  localparam logic [3:0] FN_SUB = 4'h6;

  logic          clk = 1'b0;
  logic          reset, clear, in_valid, in_ready, in_load;
  logic [3:0]    in_func, alu_func;
  logic [DW-1:0] in_operand, alu_a, alu_b, alu_c, acc_out;
  logic          alu_overflow, out_valid, ovf_sticky;
  logic [7:0]    op_count;

  int total  = 0;
  int passed = 0;

  alu_accumulator #(.data_width(DW)) dut (
    .clk(clk), .reset(reset), .clear(clear),
    .in_valid(in_valid), .in_ready(in_ready), .in_load(in_load),
    .in_func(in_func), .in_operand(in_operand),
    .alu_a(alu_a), .alu_b(alu_b), .alu_func(alu_func),
    .alu_c(alu_c), .alu_overflow(alu_overflow),
    .acc_out(acc_out), .out_valid(out_valid),
    .ovf_sticky(ovf_sticky), .op_count(op_count)
  );

  always #5 clk = ~clk;

  // Reference ALU: two's-complement add/sub with signed overflow, ID passes A.
  always_comb begin
    alu_c        = alu_a;
    alu_overflow = 1'b0;
    case (alu_func)
      FN_ADD: begin
        alu_c        = alu_a + alu_b;
        alu_overflow = (alu_a[DW-1] == alu_b[DW-1]) && (alu_c[DW-1] != alu_a[DW-1]);
      end
      FN_SUB: begin
        alu_c        = alu_a - alu_b;
        alu_overflow = (alu_a[DW-1] != alu_b[DW-1]) && (alu_c[DW-1] != alu_a[DW-1]);
      end
      default: begin
        alu_c        = alu_a;
        alu_overflow = 1'b0;
      end
    endcase
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Issue one command and check the EXEC cycle and the writeback cycle.
  task automatic cmd(input string tag, input logic ld, input logic [3:0] fn,
                     input logic [DW-1:0] opnd, input logic [DW-1:0] accBefore,
                     input logic [DW-1:0] accExp);
    int n = 0;
    while (!in_ready && n < 20) begin
      step();
      n++;
    end
    if (!in_ready) chk({tag, "_ready_timeout"}, 0, 1);
    in_valid = 1'b1; in_load = ld; in_func = fn; in_operand = opnd;
    step();
    in_valid = 1'b0;
    chk({tag, "_exec_ready"}, in_ready, 0);
    chk({tag, "_exec_vld"},   out_valid, 0);
    chk({tag, "_alu_a"},      alu_a, accBefore);
    chk({tag, "_alu_b"},      alu_b, opnd);
    chk({tag, "_alu_func"},   alu_func, fn);
    step();
    chk({tag, "_wb_vld"},   out_valid, 1);
    chk({tag, "_wb_acc"},   acc_out, accExp);
    chk({tag, "_wb_ready"}, in_ready, 1);
  endtask

  task automatic doClear();
    clear = 1'b1;
    #1;
    chk("clear_blocks_ready", in_ready, 0);
    step();
    clear = 1'b0;
    chk("clear_acc", acc_out, 0);
    chk("clear_ovf", ovf_sticky, 0);
    chk("clear_cnt", op_count, 0);
    chk("clear_vld", out_valid, 0);
  endtask

  initial begin
    reset = 1'b1; clear = 1'b0; in_valid = 1'b0; in_load = 1'b0;
    in_func = '0; in_operand = '0;
    repeat (2) @(posedge clk);
    #3 reset = 1'b0;
    #1;
    chk("rst_ready", in_ready, 1);
    chk("rst_acc", acc_out, 0);
    chk("rst_vld", out_valid, 0);
    chk("rst_ovf", ovf_sticky, 0);
    chk("rst_cnt", op_count, 0);
    chk("rst_alu_a", alu_a, 0);
    chk("rst_alu_b", alu_b, 0);
    chk("rst_alu_func", alu_func, 0);

    // Load then add
    cmd("ld5",  1'b1, FN_ID,  16'h0005, 16'h0000, 16'h0005);
    cmd("add3", 1'b0, FN_ADD, 16'h0003, 16'h0005, 16'h0008);
    chk("add3_cnt", op_count, 2);
    chk("add3_ovf", ovf_sticky, 0);
    step();
    chk("vld_one_cycle", out_valid, 0);
    chk("ports_hold_b", alu_b, 16'h0003);
    chk("ports_hold_func", alu_func, FN_ADD);

    // Signed overflow on add, sticky across ID
    cmd("ld7fff", 1'b1, FN_ID,  16'h7FFF, 16'h0008, 16'h7FFF);
    cmd("add1",   1'b0, FN_ADD, 16'h0001, 16'h7FFF, 16'h8000);
    chk("add1_ovf", ovf_sticky, 1);
    cmd("id",     1'b0, FN_ID,  16'h1234, 16'h8000, 16'h8000);
    chk("id_ovf_sticky", ovf_sticky, 1);
    chk("id_cnt", op_count, 5);

    // Overflow on subtract, then clear
    doClear();
    cmd("ld8000", 1'b1, FN_ID,  16'h8000, 16'h0000, 16'h8000);
    chk("ld8000_ovf", ovf_sticky, 0);
    cmd("sub1",   1'b0, FN_SUB, 16'h0001, 16'h8000, 16'h7FFF);
    chk("sub1_ovf", ovf_sticky, 1);
    doClear();

    // Load with an overflowing ALU op latched must not set the sticky flag
    cmd("ld7fff_b", 1'b1, FN_ID,  16'h7FFF, 16'h0000, 16'h7FFF);
    cmd("ld_ign",   1'b1, FN_ADD, 16'h0001, 16'h7FFF, 16'h0001);
    chk("ld_ign_ovf", ovf_sticky, 0);

    // Clear during EXEC discards the command
    in_valid = 1'b1; in_load = 1'b0; in_func = FN_ADD; in_operand = 16'h0100;
    step();
    in_valid = 1'b0;
    chk("clrx_exec", in_ready, 0);
    doClear();
    step();
    chk("clrx_no_vld", out_valid, 0);
    chk("clrx_acc", acc_out, 0);

    // in_valid held: accepted every other cycle only
    in_valid = 1'b1; in_load = 1'b0; in_func = FN_ADD; in_operand = 16'h0001;
    for (int k = 1; k <= 4; k++) begin
      step();
      chk($sformatf("hold_exec_ready%0d", k), in_ready, 0);
      chk($sformatf("hold_exec_vld%0d", k), out_valid, 0);
      step();
      chk($sformatf("hold_idle_ready%0d", k), in_ready, 1);
      chk($sformatf("hold_vld%0d", k), out_valid, 1);
      chk($sformatf("hold_acc%0d", k), acc_out, k);
    end
    in_valid = 1'b0;
    step();
    chk("hold_cnt", op_count, 4);

    // Reset in the middle of EXEC
    doClear();
    cmd("ld1", 1'b1, FN_ID, 16'h0001, 16'h0000, 16'h0001);
    in_valid = 1'b1; in_load = 1'b0; in_func = FN_ADD; in_operand = 16'h0010;
    step();
    in_valid = 1'b0;
    chk("rx_in_exec", in_ready, 0);
    #2 reset = 1'b1;
    #1;
    chk("rx_acc_async", acc_out, 0);
    chk("rx_vld_async", out_valid, 0);
    chk("rx_alu_b_async", alu_b, 0);
    chk("rx_cnt_async", op_count, 0);
    step();
    chk("rx_no_vld", out_valid, 0);
    chk("rx_acc_held", acc_out, 0);
    #2 reset = 1'b0;
    #1;
    chk("rx_ready_after", in_ready, 1);

    // Saturation of op_count
    in_valid = 1'b1; in_load = 1'b1; in_func = FN_ID; in_operand = 16'h00AA;
    repeat (508) step();
    chk("sat_254", op_count, 254);
    repeat (2) step();
    chk("sat_255", op_count, 255);
    repeat (90) step();
    in_valid = 1'b0;
    step();
    chk("sat_hold", op_count, 255);
    chk("sat_acc", acc_out, 16'h00AA);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule
